// File: rtl/data_bus_arbiter_if.sv
// Signal bundle between the data-bus arbiter, its two requesters and the data memory.
// slave = arbiter side, master = requester/memory side.
interface data_bus_arbiter_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int D_ADDR_WIDTH = 7
);
  logic                    cpu_req;
  logic                    cpu_we;
  logic [D_ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0]   cpu_wdata;
  logic [DATA_WIDTH-1:0]   cpu_rdata;
  logic                    cpu_ack;
  logic                    cpu_stall;

  logic                    dma_req;
  logic                    dma_we;
  logic [D_ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0]   dma_wdata;
  logic [DATA_WIDTH-1:0]   dma_rdata;
  logic                    dma_ack;

  logic                    mem_cs;
  logic                    mem_we;
  logic [D_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_cs, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_cs, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// Shares one data-memory bus between CPU MEM stage and DMA; CPU priority with a streak limit.
// Each access: grant edge, one mem_cs cycle, MEM_LATENCY cycles to ack, then one IDLE cycle.
module data_bus_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int D_ADDR_WIDTH   = 7,
  parameter int MEM_LATENCY    = 1,
  parameter int MAX_CPU_STREAK = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  data_bus_arbiter_if.slave io_bus
);
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_XFER_CPU = 2'd1;
  localparam logic [1:0] S_XFER_DMA = 2'd2;
  localparam logic [2:0] LAT_LAST   = 3'(MEM_LATENCY);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);

  logic [1:0]              r_state;
  logic [2:0]              r_cnt;
  logic [3:0]              r_streak;
  logic                    r_mem_we;
  logic [D_ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;
  logic [DATA_WIDTH-1:0]   r_cpu_rdata;
  logic [DATA_WIDTH-1:0]   r_dma_rdata;

  logic w_idle;
  logic w_xfer;
  logic w_ack_cyc;
  logic w_cpu_ack;
  logic w_dma_ack;
  logic w_grant_cpu;
  logic w_grant_dma;

  assign w_idle    = (r_state == S_IDLE);
  assign w_xfer    = (r_state == S_XFER_CPU) || (r_state == S_XFER_DMA);
  assign w_ack_cyc = w_xfer && (r_cnt == LAT_LAST);
  assign w_cpu_ack = w_ack_cyc && (r_state == S_XFER_CPU);
  assign w_dma_ack = w_ack_cyc && (r_state == S_XFER_DMA);

  // CPU wins ties until it has taken MAX_CPU_STREAK grants in a row over a waiting DMA.
  assign w_grant_cpu = w_idle && io_bus.cpu_req &&
                       (!io_bus.dma_req || (r_streak != STREAK_MAX));
  assign w_grant_dma = w_idle && io_bus.dma_req && !w_grant_cpu;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_grant_cpu) begin
            r_state     <= S_XFER_CPU;
            r_mem_we    <= io_bus.cpu_we;
            r_mem_addr  <= io_bus.cpu_addr;
            r_mem_wdata <= io_bus.cpu_wdata;
          end else if (w_grant_dma) begin
            r_state     <= S_XFER_DMA;
            r_mem_we    <= io_bus.dma_we;
            r_mem_addr  <= io_bus.dma_addr;
            r_mem_wdata <= io_bus.dma_wdata;
          end
        end
        S_XFER_CPU, S_XFER_DMA: begin
          if (w_ack_cyc) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_streak <= '0;
    end else if (w_idle) begin
      if (w_grant_dma || !io_bus.dma_req) begin
        r_streak <= '0;
      end else if (w_grant_cpu && (r_streak != 4'hF)) begin
        r_streak <= r_streak + 4'd1;
      end
    end
  end

  // Read data is held per master so each sees its last load until the next one completes.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      if (w_cpu_ack && !r_mem_we) r_cpu_rdata <= io_bus.mem_rdata;
      if (w_dma_ack && !r_mem_we) r_dma_rdata <= io_bus.mem_rdata;
    end
  end

  assign io_bus.mem_cs    = w_xfer && (r_cnt == 3'd0);
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;

  assign io_bus.cpu_ack   = w_cpu_ack;
  assign io_bus.dma_ack   = w_dma_ack;
  assign io_bus.cpu_rdata = (w_cpu_ack && !r_mem_we) ? io_bus.mem_rdata : r_cpu_rdata;
  assign io_bus.dma_rdata = (w_dma_ack && !r_mem_we) ? io_bus.mem_rdata : r_dma_rdata;
  assign io_bus.cpu_stall = i_reset && io_bus.cpu_req && !w_cpu_ack;
endmodule
